dual_port_sram_responder: RTL and testbench
===========================================

Name: dual_port_sram_responder

Overview:
- Memory-side responder for the core's two SRAM initiator ports: instruction fetch and data load/store.
- Holds a shared word array behind both ports.
- Answers reads with fixed 1-cycle latency and applies byte-strobed writes.
- Resolves same-cycle port collisions deterministically and flags out-of-range accesses for the testbench and SoC glue.

Parameters:
- ADDRESS_WIDTH, 14, number of word-index bits; array depth = 2**ADDRESS_WIDTH words.
- BASE_ADDRESS, 32'h1FC0_0000, byte address mapped to word 0; must be aligned to 4*2**ADDRESS_WIDTH.
- OUT_OF_RANGE_DATA, 32'hDEAD_BEEF, read data returned for out-of-range reads.

Ports:
- clock  input  1  single clock, all logic posedge.
- reset_  input  1  synchronous, active-low reset.
- instruction_enabled  input  1  inst port access request this cycle.
- instruction_write_strobe  input  4  inst port byte-lane write enables.
- instruction_address  input  32  inst port byte address.
- instruction_write_data  input  32  inst port write data.
- instruction_read_data  output  32  inst port read data, valid 1 cycle after request.
- data_enabled  input  1  data port access request.
- data_write_enabled  input  4  data port byte-lane write enables.
- data_address  input  32  data port byte address.
- data_write_data  input  32  data port write data.
- data_read_data  output  32  data port read data, valid 1 cycle after request.
- access_error  output  1  sticky: any out-of-range or misaligned access seen.
- access_error_address  output  32  byte address of the first erroring access.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous, active-low, on `reset_`.
- Reset values:
  - While reset_==0 at a posedge, on the next cycle: instruction_read_data=0, data_read_data=0, access_error=0, access_error_address=0.
  - All writes are suppressed during reset; requests in that cycle are ignored.
  - Array contents are NOT cleared by reset.
- Address decode, per port:
  - offset = address - BASE_ADDRESS; word index = offset[ADDRESS_WIDTH+1:2].
  - In range iff offset < 4*2**ADDRESS_WIDTH (unsigned); addresses below BASE wrap large and are out of range.
- Alignment:
  - address[1:0] != 0 is misaligned.
  - A misaligned access performs normally using index bits only (low bits ignored), but sets the error.
- Read timing:
  - A request with enabled=1 latches its read result at the posedge.
  - The result appears on *_read_data the following cycle and holds until the next enabled request on that port.
  - A port with enabled=0 holds its previous read_data.
- Write: for each lane i with strobe[i]=1, byte i of the word is replaced by write_data[8i+7:8i] at the posedge.
- Write-first on a write request: read_data next cycle returns the post-write merged word.
- Same-cycle collision, both ports enabled on the same in-range word index:
  - Lane merge order is: old word, then inst-port lanes, then data-port lanes. The data port wins any lane both ports strobe.
  - Both ports' read_data next cycle return the final merged word.
- Different indices: the ports are fully independent; both operate in the same cycle with no stall.
- Out-of-range access:
  - No array write.
  - read_data next cycle = OUT_OF_RANGE_DATA.
  - Error is set.
- Error capture:
  - access_error rises the cycle after the first erroring access and stays high until reset.
  - access_error_address latches only on the first error.
  - If both ports err in the same cycle, the data-port address is captured.
- No handshake or backpressure: latency is exactly 1 cycle, every cycle, matching the core's fixed-latency fetch/load expectation.
- Reset asserted mid-operation:
  - Any request presented in a cycle with reset_==0 is dropped.
  - The first request after reset_ returns to 1 behaves normally.

Test Plan:
- Inst read at 0x1FC0_0000, with word 0 preloaded 0x2402_0001 → instruction_read_data=0x2402_0001 exactly 1 cycle later; holds while instruction_enabled=0.
- Data write 0x1FC0_0010, strobe 4'b0011, data 0xAABB_CCDD over old 0x1122_3344 → data_read_data=0x1122_CCDD next cycle; later inst read of same address also returns 0x1122_CCDD.
- Same-cycle collision on word 0x1FC0_0020 (old 0x0):
  - Stimulus: inst strobe 4'b1111, data 0x1111_1111; data strobe 4'b0101, data 0x2222_2222.
  - Response: both ports read 0x1122_1122 next cycle.
- Out-of-range data read at 0x0000_0100 → data_read_data=0xDEAD_BEEF, access_error=1, access_error_address=0x0000_0100. A subsequent error at 0x1FC0_0002 (misaligned) leaves access_error_address unchanged.
- Reset mid-operation:
  - Stimulus: assert reset_=0 in the same cycle as a data write to 0x1FC0_0030; deassert; then read it back.
  - Response: original contents are unchanged; read_data outputs are 0 during reset; access_error is cleared.
- Back-to-back: alternating reads/writes every cycle on both ports for 1000 random in-range cycles → every read_data matches a reference model with 1-cycle latency and the collision merge order above.

Source files
------------

// File: rtl/dual_port_sram_responder.sv
// Shared word array behind the core's instruction and data SRAM ports.
// Fixed 1-cycle read latency, byte-strobed writes, deterministic same-word collision merge.
module dual_port_sram_responder #(
    parameter int          ADDRESS_WIDTH     = 14,
    parameter logic [31:0] BASE_ADDRESS      = 32'h1FC0_0000,
    parameter logic [31:0] OUT_OF_RANGE_DATA = 32'hDEAD_BEEF
) (
    input  logic        clock,
    input  logic        reset_,
    input  logic        instruction_enabled,
    input  logic [3:0]  instruction_write_strobe,
    input  logic [31:0] instruction_address,
    input  logic [31:0] instruction_write_data,
    output logic [31:0] instruction_read_data,
    input  logic        data_enabled,
    input  logic [3:0]  data_write_enabled,
    input  logic [31:0] data_address,
    input  logic [31:0] data_write_data,
    output logic [31:0] data_read_data,
    output logic        access_error,
    output logic [31:0] access_error_address
);

    localparam int          DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [31:0] SPAN  = 32'(DEPTH) * 32'd4;

    logic [31:0] mem [DEPTH];

    logic [31:0]              inst_offset, data_offset;
    logic [ADDRESS_WIDTH-1:0] inst_index, data_index;
    logic                     inst_in_range, data_in_range;
    logic                     inst_error, data_error;
    logic                     collision;
    logic [31:0]              inst_merged, data_merged, inst_result;

    function automatic logic [31:0] merge_lanes(input logic [31:0] word,
                                                input logic [3:0]  strobe,
                                                input logic [31:0] wdata);
        for (int i = 0; i < 4; i++)
            if (strobe[i]) word[8*i +: 8] = wdata[8*i +: 8];
        return word;
    endfunction

    always_comb begin
        inst_offset   = instruction_address - BASE_ADDRESS;
        data_offset   = data_address - BASE_ADDRESS;
        inst_index    = inst_offset[ADDRESS_WIDTH+1:2];
        data_index    = data_offset[ADDRESS_WIDTH+1:2];
        // Addresses below the base wrap to huge offsets and fall out of range here.
        inst_in_range = inst_offset < SPAN;
        data_in_range = data_offset < SPAN;

        collision = instruction_enabled && data_enabled && inst_in_range &&
                    data_in_range && (inst_index == data_index);

        // Data lanes land on top of instruction lanes when both hit one word.
        inst_merged = merge_lanes(mem[inst_index], instruction_write_strobe, instruction_write_data);
        data_merged = merge_lanes(collision ? inst_merged : mem[data_index],
                                  data_write_enabled, data_write_data);
        inst_result = collision ? data_merged : inst_merged;

        inst_error = instruction_enabled &&
                     (!inst_in_range || (instruction_address[1:0] != 2'b00));
        data_error = data_enabled && (!data_in_range || (data_address[1:0] != 2'b00));
    end

    // Array is not cleared by reset; only writes are suppressed while it is held.
    always_ff @(posedge clock) begin
        if (reset_) begin
            if (instruction_enabled && inst_in_range) mem[inst_index] <= inst_result;
            if (data_enabled && data_in_range)        mem[data_index] <= data_merged;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            instruction_read_data <= '0;
            data_read_data        <= '0;
            access_error          <= 1'b0;
            access_error_address  <= '0;
        end else begin
            if (instruction_enabled)
                instruction_read_data <= inst_in_range ? inst_result : OUT_OF_RANGE_DATA;
            if (data_enabled)
                data_read_data <= data_in_range ? data_merged : OUT_OF_RANGE_DATA;
            if (inst_error || data_error) begin
                access_error <= 1'b1;
                if (!access_error)
                    access_error_address <= data_error ? data_address : instruction_address;
            end
        end
    end

endmodule

// File: tb/tb_dual_port_sram_responder.sv
// Directed and randomized checks of dual_port_sram_responder against hand-computed values
// and a small word-array reference model.
module tb_dual_port_sram_responder;

    localparam logic [31:0] BASE = 32'h1FC0_0000;

    logic        clock;
    logic        reset_;
    logic        instruction_enabled;
    logic [3:0]  instruction_write_strobe;
    logic [31:0] instruction_address;
    logic [31:0] instruction_write_data;
    logic [31:0] instruction_read_data;
    logic        data_enabled;
    logic [3:0]  data_write_enabled;
    logic [31:0] data_address;
    logic [31:0] data_write_data;
    logic [31:0] data_read_data;
    logic        access_error;
    logic [31:0] access_error_address;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    dual_port_sram_responder dut (
        .clock                    (clock),
        .reset_                   (reset_),
        .instruction_enabled      (instruction_enabled),
        .instruction_write_strobe (instruction_write_strobe),
        .instruction_address      (instruction_address),
        .instruction_write_data   (instruction_write_data),
        .instruction_read_data    (instruction_read_data),
        .data_enabled             (data_enabled),
        .data_write_enabled       (data_write_enabled),
        .data_address             (data_address),
        .data_write_data          (data_write_data),
        .data_read_data           (data_read_data),
        .access_error             (access_error),
        .access_error_address     (access_error_address)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_i(input logic en, input logic [3:0] s, input logic [31:0] a,
                           input logic [31:0] d);
        instruction_enabled      = en;
        instruction_write_strobe = s;
        instruction_address      = a;
        instruction_write_data   = d;
    endtask

    task automatic drive_d(input logic en, input logic [3:0] s, input logic [31:0] a,
                           input logic [31:0] d);
        data_enabled       = en;
        data_write_enabled = s;
        data_address       = a;
        data_write_data    = d;
    endtask

    task automatic idle();
        drive_i(1'b0, 4'h0, 32'h0, 32'h0);
        drive_d(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] w, input logic [3:0] s,
                                          input logic [31:0] d);
        for (int i = 0; i < 4; i++)
            if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        return w;
    endfunction

    logic [31:0] tm [16];
    logic [31:0] exp_i, exp_d;

    initial begin
        reset_ = 1'b0;
        idle();
        tick();
        tick();
        check("reset_inst_rd", instruction_read_data, 32'h0);
        check("reset_data_rd", data_read_data, 32'h0);
        check("reset_err", {31'h0, access_error}, 32'h0);
        check("reset_err_addr", access_error_address, 32'h0);

        // Preload through the ports, different words on each port in one cycle.
        #2 reset_ = 1'b1;
        drive_d(1'b1, 4'hF, 32'h1FC0_0000, 32'h2402_0001);
        drive_i(1'b1, 4'hF, 32'h1FC0_0010, 32'h1122_3344);
        tick(); idle();
        check("preload_data_writefirst", data_read_data, 32'h2402_0001);
        check("preload_inst_writefirst", instruction_read_data, 32'h1122_3344);
        drive_d(1'b1, 4'hF, 32'h1FC0_0020, 32'h0000_0000);
        drive_i(1'b1, 4'hF, 32'h1FC0_0030, 32'h5A5A_5A5A);
        tick(); idle();

        // Fetch word 0, then hold with enable low.
        drive_i(1'b1, 4'h0, 32'h1FC0_0000, 32'h0);
        tick(); idle();
        check("inst_read_w0", instruction_read_data, 32'h2402_0001);
        tick();
        check("inst_hold_w0", instruction_read_data, 32'h2402_0001);
        check("data_hold", data_read_data, 32'h0000_0000);

        // Partial write, write-first readback, cross-port readback.
        drive_d(1'b1, 4'b0011, 32'h1FC0_0010, 32'hAABB_CCDD);
        tick(); idle();
        check("data_partial_write", data_read_data, 32'h1122_CCDD);
        drive_i(1'b1, 4'h0, 32'h1FC0_0010, 32'h0);
        tick(); idle();
        check("inst_read_partial", instruction_read_data, 32'h1122_CCDD);

        // Same-word collision: data lanes 0 and 2 win.
        drive_i(1'b1, 4'hF, 32'h1FC0_0020, 32'h1111_1111);
        drive_d(1'b1, 4'b0101, 32'h1FC0_0020, 32'h2222_2222);
        tick(); idle();
        check("collision_inst", instruction_read_data, 32'h1122_1122);
        check("collision_data", data_read_data, 32'h1122_1122);
        check("no_err_yet", {31'h0, access_error}, 32'h0);

        // Last in-range word.
        drive_d(1'b1, 4'hF, 32'h1FC0_FFFC, 32'hCAFE_F00D);
        tick(); idle();
        check("last_word_write", data_read_data, 32'hCAFE_F00D);
        drive_i(1'b1, 4'h0, 32'h1FC0_FFFC, 32'h0);
        tick(); idle();
        check("last_word_inst", instruction_read_data, 32'hCAFE_F00D);
        check("last_word_no_err", {31'h0, access_error}, 32'h0);

        // Out-of-range read below base, then later errors keep the first address.
        drive_d(1'b1, 4'h0, 32'h0000_0100, 32'h0);
        tick(); idle();
        check("oor_data_rd", data_read_data, 32'hDEAD_BEEF);
        check("oor_err", {31'h0, access_error}, 32'h1);
        check("oor_err_addr", access_error_address, 32'h0000_0100);
        drive_i(1'b1, 4'h0, 32'h1FC0_0002, 32'h0);
        tick(); idle();
        check("misaligned_rd", instruction_read_data, 32'h2402_0001);
        check("misaligned_err_addr_kept", access_error_address, 32'h0000_0100);
        // One past the end aliases word 0 in the index bits; must not write it.
        drive_i(1'b1, 4'hF, 32'h1FC1_0000, 32'hFFFF_FFFF);
        tick(); idle();
        check("past_end_rd", instruction_read_data, 32'hDEAD_BEEF);
        drive_i(1'b1, 4'h0, 32'h1FC0_0000, 32'h0);
        tick(); idle();
        check("past_end_no_write", instruction_read_data, 32'h2402_0001);
        check("err_sticky", {31'h0, access_error}, 32'h1);

        // Reset with a write in flight: write dropped, outputs cleared.
        reset_ = 1'b0;
        drive_d(1'b1, 4'hF, 32'h1FC0_0030, 32'hFFFF_FFFF);
        tick(); idle();
        check("midreset_inst_rd", instruction_read_data, 32'h0);
        check("midreset_data_rd", data_read_data, 32'h0);
        check("midreset_err", {31'h0, access_error}, 32'h0);
        check("midreset_err_addr", access_error_address, 32'h0);
        reset_ = 1'b1;
        drive_d(1'b1, 4'h0, 32'h1FC0_0030, 32'h0);
        tick(); idle();
        check("midreset_write_dropped", data_read_data, 32'h5A5A_5A5A);
        check("midreset_w0_kept", instruction_read_data, 32'h0);

        // Both ports err together: data address is captured.
        drive_i(1'b1, 4'h0, 32'h0000_0000, 32'h0);
        drive_d(1'b1, 4'h0, 32'h2000_0000, 32'h0);
        tick(); idle();
        check("dual_err", {31'h0, access_error}, 32'h1);
        check("dual_err_addr", access_error_address, 32'h2000_0000);
        check("dual_err_inst_rd", instruction_read_data, 32'hDEAD_BEEF);
        check("dual_err_data_rd", data_read_data, 32'hDEAD_BEEF);

        // Random traffic over 16 words against a reference model.
        for (int k = 0; k < 8; k++) begin
            tm[k]     = $urandom;
            tm[k + 8] = $urandom;
            drive_i(1'b1, 4'hF, BASE + 32'(4 * k), tm[k]);
            drive_d(1'b1, 4'hF, BASE + 32'(4 * (k + 8)), tm[k + 8]);
            tick();
        end
        idle();
        exp_i = tm[7];
        exp_d = tm[15];
        for (int c = 0; c < 1000; c++) begin
            logic        ie, de;
            logic [3:0]  is, ds;
            logic [31:0] iw, dw;
            int          ii, di;
            ie = 1'($urandom_range(0, 1));
            de = 1'($urandom_range(0, 1));
            is = 4'($urandom_range(0, 15));
            ds = 4'($urandom_range(0, 15));
            ii = $urandom_range(0, 15);
            di = ($urandom_range(0, 3) == 0) ? ii : $urandom_range(0, 15);
            iw = $urandom;
            dw = $urandom;
            drive_i(ie, is, BASE + 32'(4 * ii), iw);
            drive_d(de, ds, BASE + 32'(4 * di), dw);
            if (ie) tm[ii] = lanes(tm[ii], is, iw);
            if (de) tm[di] = lanes(tm[di], ds, dw);
            if (ie) exp_i = tm[ii];
            if (de) exp_d = tm[di];
            tick();
            check("rand_inst_rd", instruction_read_data, exp_i);
            check("rand_data_rd", data_read_data, exp_d);
        end
        idle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
